// File: rtl/barrel_shifter_left_seq_if.sv
// Operand/result handshake bundle for the sequential left shifter.
// The producer/consumer side uses the master modport; the shifter uses slave.
interface barrel_shifter_left_seq_if #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in;
    logic [SHAMT_W-1:0] ctrl;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out;
    logic               busy;

    modport master (
        output in_valid, in, ctrl, out_ready,
        input  in_ready, out_valid, out, busy
    );

    modport slave (
        input  in_valid, in, ctrl, out_ready,
        output in_ready, out_valid, out, busy
    );
endinterface

// File: rtl/barrel_shifter_left_seq.sv
// Sequential logical left shifter: one 2^k stage per clock, MSB stage first,
// zero-fill from the LSB end. Latency is always SHAMT_W cycles in SHIFT.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | in_ready=1, waiting for an operand
//   SHIFT | applying stages 2^(SHAMT_W-1) .. 2^0, one per clock
//   DONE  | out_valid=1, result held until out_ready
//
// The stage index is kept one-hot (stage_q) so that its numeric value is
// directly the shift distance of the current stage, and the amount bit for
// the stage is just a masked OR.
module barrel_shifter_left_seq #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
) (
    input logic                      clk,
    input logic                      rst,
    barrel_shifter_left_seq_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [SHAMT_W-1:0] amt_q, amt_d;
    logic [SHAMT_W-1:0] stage_q, stage_d;

    logic               accept;
    logic               last_stage;
    logic               stage_hit;
    logic [WIDTH-1:0]   shifted;
    logic               in_ready_o;
    logic               out_valid_o;
    logic               busy_o;

    // Handshake qualifiers and the single shift stage for this cycle.
    always_comb begin
        accept     = bus.in_valid && (state_q == S_IDLE);
        last_stage = stage_q[0];
        stage_hit  = |(amt_q & stage_q);
        shifted    = data_q << stage_q;
    end

    // State register plus datapath registers; reset clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            out_q   <= '0;
            amt_q   <= '0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            out_q   <= out_d;
            amt_q   <= amt_d;
            stage_q <= stage_d;
        end
    end

    // Next-state logic: fixed SHAMT_W cycles in SHIFT, hold in DONE until taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept)        state_d = S_SHIFT;
            S_SHIFT: if (last_stage)    state_d = S_DONE;
            S_DONE:  if (bus.out_ready) state_d = S_IDLE;
            default:                    state_d = S_IDLE;
        endcase
    end

    // Datapath next values: capture on accept, one stage per SHIFT cycle.
    always_comb begin
        data_d  = data_q;
        out_d   = out_q;
        amt_d   = amt_q;
        stage_d = stage_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    data_d  = bus.in;
                    amt_d   = bus.ctrl;
                    stage_d = '0;
                    stage_d[SHAMT_W-1] = 1'b1;
                end
            end
            S_SHIFT: begin
                if (stage_hit) begin
                    data_d = shifted;
                end
                stage_d = stage_q >> 1;
                // Result register only changes when a new result is complete,
                // so out keeps its last value after the output handshake.
                if (last_stage) begin
                    out_d = stage_hit ? shifted : data_q;
                end
            end
            default: begin
            end
        endcase
    end

    // Output decode purely from state: no path from out_ready to in_ready.
    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        case (state_q)
            S_IDLE:  in_ready_o = 1'b1;
            S_SHIFT: busy_o     = 1'b1;
            S_DONE: begin
                out_valid_o = 1'b1;
                busy_o      = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.in_ready  = in_ready_o;
    assign bus.out_valid = out_valid_o;
    assign bus.busy      = busy_o;
    assign bus.out       = out_q;

endmodule

// File: tb/tb_barrel_shifter_left_seq.sv
// Directed-vector and random scoreboard bench for barrel_shifter_left_seq.
module tb_barrel_shifter_left_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;

    barrel_shifter_left_seq_if #(.WIDTH(8), .SHAMT_W(3)) bus ();

    barrel_shifter_left_seq #(.WIDTH(8), .SHAMT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] din;
        logic [2:0] sh;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[8];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Waits (at negedges) for out_valid; returns cycles waited, -1 on timeout.
    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) n = -1;
    endtask

    // One operation with out_ready high; called at a negedge while IDLE.
    task automatic run_op(input logic [7:0] d, input logic [2:0] s,
                          input logic [7:0] e, input string nm);
        int n;
        check({nm, " in_ready_idle"}, bus.in_ready, 1);
        bus.in       = d;
        bus.ctrl     = s;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({nm, " busy_shift"}, bus.busy, 1);
        wait_valid(n);
        check({nm, " latency"}, n, 3);
        check({nm, " out"}, bus.out, e);
        check({nm, " in_ready_done"}, bus.in_ready, 0);
        @(negedge clk);
        check({nm, " out_valid_after"}, bus.out_valid, 0);
        check({nm, " in_ready_after"}, bus.in_ready, 1);
        check({nm, " out_hold"}, bus.out, e);
    endtask

    logic [7:0] q_exp[$];

    initial begin
        int n;
        int sent, got, cyc;
        logic pending;
        logic [7:0] din, e;
        logic [2:0] dsh;

        vecs[0] = '{8'hB5, 3'd3, 8'hA8};
        vecs[1] = '{8'hFF, 3'd7, 8'h80};
        vecs[2] = '{8'h0F, 3'd4, 8'hF0};
        vecs[3] = '{8'h81, 3'd5, 8'h20};
        vecs[4] = '{8'h3C, 3'd0, 8'h3C};
        vecs[5] = '{8'h01, 3'd7, 8'h80};
        vecs[6] = '{8'hC3, 3'd1, 8'h86};
        vecs[7] = '{8'h55, 3'd6, 8'h40};

        bus.in_valid  = 1'b0;
        bus.in        = '0;
        bus.ctrl      = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst in_ready", bus.in_ready, 1);
        check("rst out_valid", bus.out_valid, 0);
        check("rst out", bus.out, 0);
        check("rst busy", bus.busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].din, vecs[i].sh, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Backpressure, with a second operand held pending
        bus.in = 8'h01; bus.ctrl = 3'd6; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in = 8'h77; bus.ctrl = 3'd1;
        wait_valid(n);
        check("bp latency", n, 3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp out_valid", bus.out_valid, 1);
            check("bp out", bus.out, 8'h40);
            check("bp in_ready", bus.in_ready, 0);
            check("bp busy", bus.busy, 1);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp released out_valid", bus.out_valid, 0);
        check("bp released in_ready", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp second accepted busy", bus.busy, 1);
        check("bp second in_ready", bus.in_ready, 0);
        wait_valid(n);
        check("bp second latency", n, 3);
        check("bp second out", bus.out, 8'hEE);
        @(negedge clk);

        // Input isolation
        bus.in = 8'h11; bus.ctrl = 3'd1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in = 8'hFF; bus.ctrl = 3'd7;
        wait_valid(n);
        check("iso latency", n, 3);
        check("iso out", bus.out, 8'h22);
        @(negedge clk);

        // Reset in the second SHIFT cycle
        bus.in = 8'hAA; bus.ctrl = 3'd2; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid rst out_valid", bus.out_valid, 0);
        check("mid rst out", bus.out, 0);
        check("mid rst in_ready", bus.in_ready, 1);
        check("mid rst busy", bus.busy, 0);
        @(negedge clk);
        rst = 1'b0;
        check("post rst out_valid", bus.out_valid, 0);
        run_op(8'h03, 3'd1, 8'h06, "post rst");

        // Random scoreboard
        sent = 0; got = 0; cyc = 0; pending = 1'b0;
        din = '0; dsh = '0;
        while ((sent < 1000 || got < 1000) && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (!pending && sent < 1000 && $urandom_range(0, 3) != 0) begin
                pending = 1'b1;
                din = 8'($urandom_range(0, 255));
                dsh = 3'($urandom_range(0, 7));
            end
            bus.in_valid  = pending;
            bus.in        = din;
            bus.ctrl      = dsh;
            bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            if (pending && bus.in_ready) begin
                e = din << dsh;
                q_exp.push_back(e);
                pending = 1'b0;
                sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q_exp.size() == 0) begin
                    check("rand unexpected result", 1, 0);
                end else begin
                    e = q_exp.pop_front();
                    check("rand out", bus.out, e);
                end
                got++;
            end
        end
        bus.in_valid = 1'b0;
        check("rand results received", got, 1000);
        check("rand scoreboard empty", q_exp.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/barrel_shifter_left_seq.md
Name: barrel_shifter_left_seq

Overview:
Sequential logical left shifter. It is the opposite direction to the team's combinational 8-bit right barrel shifter. The block accepts one operand and a shift amount through a valid/ready handshake. It then applies the 4/2/1 shift stages one per clock, MSB stage first, with zero-fill from the LSB end. The result is presented on a valid/ready output. It sits in the datapath wherever a left shift is needed and single-cycle mux depth is not affordable.

Parameters:
WIDTH, 8, operand/result width in bits (power of two, >= 2)
SHAMT_W, 3, shift-amount width; must equal log2(WIDTH)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  operand/amount on in/ctrl are valid
in_ready  output  1  block can accept a new operand
in  input  WIDTH  operand
ctrl  input  SHAMT_W  left-shift amount, 0..WIDTH-1
out_valid  output  1  result on out is valid
out_ready  input  1  consumer accepts result
out  output  WIDTH  shifted result
busy  output  1  high in SHIFT or DONE state

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out=0, busy=0. Internal data, amount and stage registers are cleared to 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE
  - in_ready=1.
  - On in_valid&&in_ready at a rising edge: latch in→data_q and ctrl→amt_q, set stage index k=SHAMT_W-1, go to SHIFT.
  - If in_valid=0: stay in IDLE.
- SHIFT
  - in_ready=0.
  - Each cycle, if amt_q[k]=1: data_q <= data_q << 2^k, zero-fill, truncated to WIDTH. Otherwise data_q is unchanged.
  - If k==0: go to DONE. Otherwise k <= k-1.
  - Exactly SHAMT_W cycles are spent in SHIFT, regardless of ctrl value. Stages are never skipped, so latency is data-independent.
- DONE
  - out_valid=1, out=data_q.
  - On out_ready=1: go to IDLE. out_valid drops and out holds its last value.
  - If out_ready=0: stay in DONE. out and out_valid stay stable until the handshake completes.
- Latency: acceptance edge T → out_valid=1 after edge T+SHAMT_W (3 cycles for the default). out_ready may already be high when out_valid rises; the transfer then completes at the next edge.
- Throughput: at most one operation per SHAMT_W+2 cycles. in_ready is high only in IDLE; there is no accept in DONE.
- Inputs in/ctrl are sampled only on the acceptance edge. Changes afterwards have no effect on the operation in flight.
- out is registered (driven from data_q). No combinational path from in/ctrl to out, or from out_ready to in_ready.
- Width rules:
  - Result = (in << ctrl) mod 2^WIDTH.
  - Bits shifted past MSB are discarded.
  - ctrl=0 returns in unchanged after the full latency.
- Reset mid-operation: asserting rst in any state immediately (asynchronously) forces the reset values. The in-flight operation is discarded and no out_valid is produced for it. The first accept after reset release occurs no earlier than the first rising edge with rst=0.
- in_valid asserted while in_ready=0: ignored; the producer must hold it.
- out_ready asserted while out_valid=0: ignored.

Test Plan:
1. Reset, then in=8'hB5, ctrl=3, in_valid pulse, out_ready=1 → out_valid high exactly 3 cycles after acceptance with out=8'hA8; in_ready returns to 1 one cycle after the output handshake.
2. Sweep: in=8'hFF with ctrl=7 → 8'h80; in=8'h0F, ctrl=4 → 8'hF0; in=8'h81, ctrl=5 → 8'h20; in=8'h3C, ctrl=0 → 8'h3C. Each case has 3-cycle latency.
3. Backpressure: in=8'h01, ctrl=6, out_ready=0 for 5 cycles after out_valid → out=8'h40 and out_valid stable throughout, in_ready=0 and busy=1; with in_valid held high and a new in, no accept occurs until after the out handshake.
4. Input isolation: accept in=8'h11, ctrl=1, then change in=8'hFF, ctrl=7 during SHIFT → out=8'h22.
5. Reset mid-operation: accept in=8'hAA, ctrl=2, assert rst between clock edges in the second SHIFT cycle → out_valid=0, out=0, in_ready=1 immediately; after release, in=8'h03, ctrl=1 → out=8'h06 with normal latency.
6. Random scoreboard: 1000 random in/ctrl with random in_valid/out_ready gaps → every result equals (in<<ctrl)&8'hFF, in order, none dropped or duplicated.
